// File: rtl/interrupt_arbiter.sv
// Interrupt front-end for the multi-cycle MIPS Controller: latches maskable and
// non-maskable requests, arbitrates them and runs the INT/NMI acknowledge handshake.
module interrupt_arbiter #(
    parameter int N_IRQ = 4
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic [N_IRQ-1:0] IRQ,
    input  logic             NMI_IN,
    input  logic             MaskWrite,
    input  logic [N_IRQ-1:0] MaskData,
    input  logic             IntAck,
    input  logic             NmiAck,
    input  logic             Eret,
    output logic             INT,
    output logic             NMI,
    output logic             INT_FLAG,
    output logic [2:0]       Cause,
    output logic [N_IRQ-1:0] Pending
);

    localparam logic [2:0] NMI_CAUSE = 3'd7;

    typedef enum logic [2:0] {
        S_IDLE,
        S_INT_REQ,
        S_INT_SRV,
        S_NMI_REQ,
        S_NMI_SRV
    } state_t;

    state_t           state, state_n;
    logic [N_IRQ-1:0] mask;
    logic [N_IRQ-1:0] eligible;
    logic [7:0]       eligible_ext;
    logic [N_IRQ-1:0] clr;
    logic [N_IRQ-1:0] pending_n;
    logic [2:0]       low_idx;
    logic [2:0]       cause_n;
    logic [2:0]       saved_cause, saved_cause_n;
    logic             saved_srv, saved_srv_n;
    logic             nmi_pend, nmi_pend_n;
    logic             nmi_prev;
    logic             ack_int, ack_nmi;

    // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        eligible     = Pending & mask;
        eligible_ext = 8'(eligible);
        low_idx      = '0;
        for (int i = N_IRQ - 1; i >= 0; i--) begin
            if (eligible[i]) low_idx = 3'(i);
        end

        state_n       = state;
        cause_n       = Cause;
        saved_srv_n   = saved_srv;
        saved_cause_n = saved_cause;
        ack_int       = 1'b0;
        ack_nmi       = 1'b0;

        unique case (state)
            S_IDLE: begin
                if (nmi_pend) begin
                    state_n = S_NMI_REQ;
                    cause_n = NMI_CAUSE;
                end else if (eligible != '0) begin
                    state_n = S_INT_REQ;
                    cause_n = low_idx;
                end
            end
            S_INT_REQ: begin
                if (nmi_pend) begin
                    state_n     = S_NMI_REQ;
                    cause_n     = NMI_CAUSE;
                    saved_srv_n = 1'b0;
                end else if (IntAck) begin
                    state_n = S_INT_SRV;
                    ack_int = 1'b1;
                end else if (!eligible_ext[Cause]) begin
                    state_n = S_IDLE;
                end
            end
            S_INT_SRV: begin
                if (nmi_pend) begin
                    state_n       = S_NMI_REQ;
                    saved_srv_n   = 1'b1;
                    saved_cause_n = Cause;
                    cause_n       = NMI_CAUSE;
                end else if (Eret) begin
                    state_n = S_IDLE;
                end
            end
            S_NMI_REQ: begin
                if (NmiAck) begin
                    state_n = S_NMI_SRV;
                    ack_nmi = 1'b1;
                end
            end
            S_NMI_SRV: begin
                if (Eret) begin
                    if (saved_srv) begin
                        state_n     = S_INT_SRV;
                        cause_n     = saved_cause;
                        saved_srv_n = 1'b0;
                    end else begin
                        state_n = S_IDLE;
                    end
                end
            end
            default: state_n = S_IDLE;
        endcase

        // An acknowledge clears the serviced bit even if its level is still high; it re-pends next edge.
        clr = '0;
        for (int i = 0; i < N_IRQ; i++) begin
            if (ack_int && Cause == 3'(i)) clr[i] = 1'b1;
        end
        pending_n = (Pending | (IRQ & mask)) & ~clr;

        if (ack_nmi)                  nmi_pend_n = 1'b0;
        else if (NMI_IN && !nmi_prev) nmi_pend_n = 1'b1;
        else                          nmi_pend_n = nmi_pend;
    end

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values regardless of statement order.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state       <= S_IDLE;
            mask        <= '0;
            Pending     <= '0;
            Cause       <= '0;
            saved_cause <= '0;
            saved_srv   <= 1'b0;
            nmi_pend    <= 1'b0;
            nmi_prev    <= 1'b0;
            INT         <= 1'b0;
            NMI         <= 1'b0;
            INT_FLAG    <= 1'b0;
        end else begin
            state       <= state_n;
            if (MaskWrite) mask <= MaskData;
            Pending     <= pending_n;
            Cause       <= cause_n;
            saved_cause <= saved_cause_n;
            saved_srv   <= saved_srv_n;
            nmi_pend    <= nmi_pend_n;
            nmi_prev    <= NMI_IN;
            // Outputs are decoded from the next state so they appear with the state itself.
            INT         <= (state_n == S_INT_REQ);
            NMI         <= (state_n == S_NMI_REQ);
            INT_FLAG    <= (state_n == S_INT_SRV) ||
                           (((state_n == S_NMI_REQ) || (state_n == S_NMI_SRV)) && saved_srv_n);
        end
    end

endmodule

// File: tb/tb_interrupt_arbiter.sv
// Directed bench for interrupt_arbiter: hand-computed expectations for arbitration,
// masking, NMI nesting, NMI edge detection and asynchronous reset.
module tb_interrupt_arbiter;

    localparam int N_IRQ = 4;

    logic             Clk = 1'b0;
    logic             Rst_n;
    logic [N_IRQ-1:0] IRQ;
    logic             NMI_IN;
    logic             MaskWrite;
    logic [N_IRQ-1:0] MaskData;
    logic             IntAck;
    logic             NmiAck;
    logic             Eret;
    logic             INT;
    logic             NMI;
    logic             INT_FLAG;
    logic [2:0]       Cause;
    logic [N_IRQ-1:0] Pending;

    int errors = 0;
    int checks = 0;

    interrupt_arbiter #(.N_IRQ(N_IRQ)) dut (
        .Clk       (Clk),
        .Rst_n     (Rst_n),
        .IRQ       (IRQ),
        .NMI_IN    (NMI_IN),
        .MaskWrite (MaskWrite),
        .MaskData  (MaskData),
        .IntAck    (IntAck),
        .NmiAck    (NmiAck),
        .Eret      (Eret),
        .INT       (INT),
        .NMI       (NMI),
        .INT_FLAG  (INT_FLAG),
        .Cause     (Cause),
        .Pending   (Pending)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One rising edge, then settle just after it so outputs are sampled away from the edge.
    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic check_outs(input string tag, input logic i, input logic n,
                              input logic f, input logic [2:0] c);
        check({tag, ".INT"},      8'(INT),      8'(i));
        check({tag, ".NMI"},      8'(NMI),      8'(n));
        check({tag, ".INT_FLAG"}, 8'(INT_FLAG), 8'(f));
        check({tag, ".Cause"},    8'(Cause),    8'(c));
    endtask

    int nmi_rises;
    logic nmi_last;

    initial begin
        Rst_n = 1'b0; IRQ = '0; NMI_IN = 1'b0; MaskWrite = 1'b0; MaskData = '0;
        IntAck = 1'b0; NmiAck = 1'b0; Eret = 1'b0;
        #12;
        check_outs("reset", 1'b0, 1'b0, 1'b0, 3'd0);
        check("reset.Pending", 8'(Pending), 8'h00);
        @(negedge Clk);
        Rst_n = 1'b1;

        // Single source, full handshake.
        MaskWrite = 1'b1; MaskData = 4'b1111;
        tick();
        MaskWrite = 1'b0; IRQ = 4'b0100;
        tick();
        check("t1.Pending", 8'(Pending), 8'h04);
        check("t1.INT_early", 8'(INT), 8'h00);
        tick();
        check_outs("t1.req", 1'b1, 1'b0, 1'b0, 3'd2);
        IRQ = '0; IntAck = 1'b1;
        tick();
        check_outs("t1.srv", 1'b0, 1'b0, 1'b1, 3'd2);
        check("t1.Pending_clr", 8'(Pending), 8'h00);
        IntAck = 1'b0; Eret = 1'b1;
        tick();
        Eret = 1'b0;
        check("t1.idle.INT", 8'(INT), 8'h00);
        check("t1.idle.NMI", 8'(NMI), 8'h00);
        check("t1.idle.INT_FLAG", 8'(INT_FLAG), 8'h00);

        // Two simultaneous sources: lower index first, then the remaining one back-to-back.
        IRQ = 4'b1010;
        tick();
        check("t2.Pending", 8'(Pending), 8'h0a);
        tick();
        check_outs("t2.req1", 1'b1, 1'b0, 1'b0, 3'd1);
        IRQ = 4'b1000; IntAck = 1'b1;
        tick();
        check("t2.Pending_after_ack", 8'(Pending), 8'h08);
        IntAck = 1'b0; Eret = 1'b1;
        tick();
        Eret = 1'b0;
        check("t2.idle.INT", 8'(INT), 8'h00);
        tick();
        check_outs("t2.req3", 1'b1, 1'b0, 1'b0, 3'd3);
        IRQ = '0; IntAck = 1'b1;
        tick();
        IntAck = 1'b0; Eret = 1'b1;
        tick();
        Eret = 1'b0;
        check("t2.Pending_empty", 8'(Pending), 8'h00);

        // Masked source never pends; unmasking lets it through within three edges.
        MaskWrite = 1'b1; MaskData = 4'b1110;
        tick();
        MaskWrite = 1'b0; IRQ = 4'b0001;
        tick();
        tick();
        check("t3.masked.INT", 8'(INT), 8'h00);
        check("t3.masked.Pending", 8'(Pending), 8'h00);
        MaskWrite = 1'b1; MaskData = 4'b1111;
        tick();
        MaskWrite = 1'b0;
        tick();
        tick();
        check_outs("t3.unmasked", 1'b1, 1'b0, 1'b0, 3'd0);
        IRQ = '0; IntAck = 1'b1;
        tick();
        IntAck = 1'b0; Eret = 1'b1;
        tick();
        Eret = 1'b0;

        // NMI nested inside a maskable handler, then restored.
        IRQ = 4'b0100;
        tick();
        tick();
        check_outs("t4.req", 1'b1, 1'b0, 1'b0, 3'd2);
        IRQ = '0; IntAck = 1'b1;
        tick();
        IntAck = 1'b0; NMI_IN = 1'b1;
        tick();
        NMI_IN = 1'b0;
        tick();
        check_outs("t4.nmi_req", 1'b0, 1'b1, 1'b1, 3'd7);
        NmiAck = 1'b1;
        tick();
        NmiAck = 1'b0;
        check_outs("t4.nmi_srv", 1'b0, 1'b0, 1'b1, 3'd7);
        Eret = 1'b1;
        tick();
        Eret = 1'b0;
        check_outs("t4.restored", 1'b0, 1'b0, 1'b1, 3'd2);
        tick();
        Eret = 1'b1;
        tick();
        Eret = 1'b0;
        check_outs("t4.idle", 1'b0, 1'b0, 1'b0, 3'd2);

        // NMI_IN held high for 10 edges yields exactly one request.
        nmi_rises = 0;
        nmi_last  = NMI;
        NMI_IN    = 1'b1;
        for (int i = 0; i < 10; i++) begin
            NmiAck = (i == 2);
            Eret   = (i == 3);
            tick();
            if (NMI && !nmi_last) nmi_rises++;
            nmi_last = NMI;
        end
        NmiAck = 1'b0; Eret = 1'b0; NMI_IN = 1'b0;
        check("t5.nmi_count", 8'(nmi_rises), 8'd1);
        check("t5.NMI_after", 8'(NMI), 8'h00);

        // NMI preempts an outstanding INT request; the maskable request returns afterwards.
        IRQ = 4'b0010;
        tick();
        tick();
        check_outs("t6.req", 1'b1, 1'b0, 1'b0, 3'd1);
        NMI_IN = 1'b1;
        tick();
        NMI_IN = 1'b0;
        check("t6.INT_held", 8'(INT), 8'h01);
        tick();
        check_outs("t6.preempt", 1'b0, 1'b1, 1'b0, 3'd7);
        NmiAck = 1'b1;
        tick();
        NmiAck = 1'b0; Eret = 1'b1;
        tick();
        Eret = 1'b0;
        check("t6.idle.NMI", 8'(NMI), 8'h00);
        tick();
        check_outs("t6.reraise", 1'b1, 1'b0, 1'b0, 3'd1);

        // Asynchronous reset in the middle of a maskable service.
        IntAck = 1'b1;
        tick();
        IntAck = 1'b0;
        tick();
        check_outs("t7.srv", 1'b0, 1'b0, 1'b1, 3'd1);
        check("t7.Pending_repend", 8'(Pending), 8'h02);
        #2;
        Rst_n = 1'b0;
        #1;
        check_outs("t7.async_reset", 1'b0, 1'b0, 1'b0, 3'd0);
        check("t7.Pending", 8'(Pending), 8'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/interrupt_arbiter.md
# interrupt_arbiter

Interrupt front-end for the multi-cycle MIPS `Controller`. It collects several maskable interrupt lines and one non-maskable line, prioritises and latches them, and presents one request at a time on the Controller's `INT`/`NMI`/`INT_FLAG` inputs. It completes the handshake using the Controller's `intrupt`/`nmi_intrupt` acknowledge outputs and a return-from-handler pulse, and supplies a cause code to the datapath for the handler.

## Interface
- `N_IRQ`, default 4: number of maskable sources; legal range 2..7.
- `Clk` in 1: single clock; all state changes on the rising edge.
- `Rst_n` in 1: asynchronous, active-low reset.
- `IRQ` in N_IRQ: level maskable requests; bit 0 has the highest priority.
- `NMI_IN` in 1: non-maskable request, rising-edge sensitive.
- `MaskWrite` in 1: when 1, `Mask` <= `MaskData` at the edge.
- `MaskData` in N_IRQ: new mask value; 1 = source enabled.
- `IntAck` in 1: Controller `intrupt`; maskable request accepted.
- `NmiAck` in 1: Controller `nmi_intrupt`; NMI accepted.
- `Eret` in 1: one-cycle pulse, handler finished.
- `INT` out 1: maskable request to the Controller.
- `NMI` out 1: non-maskable request to the Controller.
- `INT_FLAG` out 1: 1 while a maskable handler is in service; the Controller ignores `INT` while it is set.
- `Cause` out 3: index of the source being requested or serviced; 3'd7 = NMI.
- `Pending` out N_IRQ: sticky pending register, exposed for the bench and for status reads.

## Operation
- Reset values: `Pending`=0, `Mask`=0, `INT`=0, `NMI`=0, `INT_FLAG`=0, `Cause`=0, `nmi_pend`=0, `nmi_prev`=0, `saved_srv`=0, state IDLE. Reset mid-operation aborts any request or service immediately.
- `Pending[i]` is set at every edge where `IRQ[i]` & `Mask[i]` = 1.
- `Pending[i]` is cleared at the `IntAck` edge when i = `Cause`. A simultaneous set and clear of the same bit: clear wins. A still-high level re-pends that bit on the next edge.
- Eligible = `Pending` & `Mask`. Masking a bit hides it without clearing it.
- `nmi_pend` is set at an edge where `NMI_IN`=1 and `nmi_prev`=0, in any state. It is cleared at the `NmiAck` edge. An edge arriving while `nmi_pend`=1 is merged.
- States and outputs:
  - IDLE: all outputs 0 except `Cause`.
  - INT_REQ: `INT`=1.
  - INT_SRV: `INT_FLAG`=1.
  - NMI_REQ: `NMI`=1.
  - NMI_SRV: all outputs 0.
  - `INT_FLAG` is also 1 in NMI_REQ and NMI_SRV when `saved_srv`=1.
- Transitions, in priority order:
  - IDLE: `nmi_pend` -> NMI_REQ with `Cause`=7. Otherwise, eligible≠0 -> INT_REQ with `Cause`=lowest set eligible index.
  - INT_REQ: `nmi_pend` -> NMI_REQ (withdraw `INT`, `Cause`=7, `saved_srv`=0). Else `IntAck` -> INT_SRV. Else the `Cause` bit is no longer eligible (masked) -> IDLE. `Cause` stays frozen while in INT_REQ; a higher-priority arrival does not re-arbitrate.
  - INT_SRV: `nmi_pend` -> NMI_REQ with `saved_srv`=1 and the maskable cause saved internally. Else `Eret` -> IDLE.
  - NMI_REQ: `NmiAck` -> NMI_SRV. Other inputs are ignored.
  - NMI_SRV: `Eret` -> INT_SRV if `saved_srv`, restoring the saved `Cause` and clearing `saved_srv`; else -> IDLE.
- `Eret` in IDLE, INT_REQ or NMI_REQ is ignored. `IntAck` outside INT_REQ and `NmiAck` outside NMI_REQ are ignored and clear nothing.
- `MaskWrite` takes effect at its edge and is usable for arbitration from the next edge.

## Timing
- IRQ latency: `IRQ[i]` high before edge t -> `Pending[i]`=1 after t -> `INT`=1 and `Cause`=i after t+1, when idle and enabled.
- NMI latency: `NMI_IN` rising before edge t -> `nmi_pend` after t -> `NMI`=1 after t+1.
- `INT`/`NMI` drop in the cycle after the acknowledge edge. The acknowledge may arrive any number of cycles later; there is no timeout.
- Back-to-back: after `Eret` at edge t (state returns to IDLE), a remaining eligible source raises `INT` after t+1.
- All outputs are registered; there is no combinational input-to-output path.

## Test plan
- Reset with `Mask`=4'b1111 written; `IRQ`=4'b0100 -> `Pending`=4'b0100 one edge later, `INT`=1 and `Cause`=2 two edges later; `IntAck` -> `INT`=0, `INT_FLAG`=1; `Eret` -> IDLE with all outputs 0.
- `IRQ`=4'b1010 simultaneously -> `Cause`=1 first. After `Eret`, with `IRQ`[3] still high, the next request has `Cause`=3.
- `Mask`=4'b1110, `IRQ`[0]=1 -> no `INT` and `Pending`[0]=0. Write `Mask`=4'b1111 -> `INT`=1 with `Cause`=0 within 3 edges.
- In INT_SRV with `Cause`=2, pulse `NMI_IN` -> `NMI`=1, `Cause`=7, `INT_FLAG` stays 1; `NmiAck`, then `Eret` -> INT_SRV with `Cause`=2; a second `Eret` -> IDLE.
- `NMI_IN` held high for 10 cycles -> exactly one NMI request. `NMI_IN` rising while in INT_REQ -> `INT` withdrawn and `NMI`=1; after the NMI service completes, the maskable request is re-raised.
- Assert `Rst_n`=0 asynchronously mid-INT_SRV -> all outputs 0 immediately, with no clock edge required.
